// File: rtl/soc_addr_decoder_n_if.sv
// Bus bundle between the MIPS data port, the address decoder and its slaves.
// The slave modport is the decoder's view; the master modport is the surrounding system.
interface soc_addr_decoder_n_if #(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int RS_W    = $clog2(NUM_SLV + 1)
);
  logic               req;
  logic               we;
  logic [ADDR_W-1:0]  addr;
  logic [NUM_SLV-1:0] slv_ready;
  logic               err_clr;
  logic [NUM_SLV-1:0] slv_sel;
  logic [NUM_SLV-1:0] slv_we;
  logic               bus_ready;
  logic [RS_W-1:0]    rd_sel;
  logic               rd_sel_valid;
  logic               err_pulse;
  logic               err_sticky;
  logic [ADDR_W-1:0]  err_addr;

  modport slave (
    input  req, we, addr, slv_ready, err_clr,
    output slv_sel, slv_we, bus_ready, rd_sel, rd_sel_valid,
           err_pulse, err_sticky, err_addr
  );

  modport master (
    output req, we, addr, slv_ready, err_clr,
    input  slv_sel, slv_we, bus_ready, rd_sel, rd_sel_valid,
           err_pulse, err_sticky, err_addr
  );
endinterface

// File: rtl/soc_addr_decoder_n.sv
// Region-map address decoder with per-slave wait states, access timeout,
// registered read-mux select and sticky bus-error capture.
module soc_addr_decoder_n #(
  parameter int ADDR_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int SEL_HI      = 11,
  parameter int SEL_LO      = 8,
  parameter int PERIPH_BASE = 8,
  parameter int TIMEOUT     = 15,
  parameter int RS_W        = $clog2(NUM_SLV + 1)
) (
  input logic               clk,
  input logic               rst_n,
  soc_addr_decoder_n_if.slave bus
);

  localparam int CODE_W = SEL_HI - SEL_LO + 1;
  localparam int CNT_W  = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [RS_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RS_W-1:0]    rd_sel_q, rd_sel_d;
  logic               rd_valid_q, rd_valid_d;
  logic               sticky_q, sticky_d;
  logic [ADDR_W-1:0]  err_addr_q, err_addr_d;

  logic [CODE_W-1:0]  code_s;
  logic               hit_s;
  logic [RS_W-1:0]    map_idx_s;
  logic [RS_W-1:0]    cur_idx_s;
  logic [NUM_SLV-1:0] cur_oh_s;
  logic               rdy_hit_s;
  logic               timeout_s;
  logic [NUM_SLV-1:0] sel_s;
  logic               bus_ready_s;
  logic               err_s;
  logic               read_done_s;

  assign code_s    = bus.addr[SEL_HI:SEL_LO];
  assign cur_idx_s = (state_q == ST_WAIT) ? idx_q : map_idx_s;
  assign rdy_hit_s = |(bus.slv_ready & cur_oh_s);
  assign timeout_s = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Region decode: code 0 is data memory, a contiguous code block maps the peripherals.
  always_comb begin
    hit_s     = 1'b0;
    map_idx_s = '0;
    if (code_s == '0) begin
      hit_s     = 1'b1;
      map_idx_s = '0;
    end else begin
      for (int k = 1; k < NUM_SLV; k++) begin
        if (code_s == CODE_W'(PERIPH_BASE + k - 1)) begin
          hit_s     = 1'b1;
          map_idx_s = RS_W'(k);
        end
      end
    end
  end

  // One-hot form of the slave currently addressed (decoded or captured).
  always_comb begin
    cur_oh_s = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      cur_oh_s[k] = (cur_idx_s == RS_W'(k));
    end
  end

  // State register and all sequential bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      rd_sel_q   <= RS_W'(NUM_SLV);
      rd_valid_q <= 1'b0;
      sticky_q   <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rd_sel_q   <= rd_sel_d;
      rd_valid_q <= rd_valid_d;
      sticky_q   <= sticky_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Next-state logic: enter WAIT only for a mapped slave that is not ready yet.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req && hit_s && !rdy_hit_s) begin
          state_d = ST_WAIT;
          idx_d   = map_idx_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus_ready_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic; a ready slave beats a timeout landing on the same cycle.
  always_comb begin
    sel_s       = '0;
    bus_ready_s = 1'b0;
    err_s       = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req && hit_s) begin
            sel_s       = cur_oh_s;
            bus_ready_s = rdy_hit_s;
          end else if (bus.req) begin
            bus_ready_s = 1'b1;
            err_s       = 1'b1;
          end else begin
            sel_s = '0;
          end
        end
        ST_WAIT: begin
          if (rdy_hit_s) begin
            sel_s       = cur_oh_s;
            bus_ready_s = 1'b1;
          end else if (timeout_s) begin
            bus_ready_s = 1'b1;
            err_s       = 1'b1;
          end else begin
            sel_s = cur_oh_s;
          end
        end
        default: begin
          sel_s = '0;
        end
      endcase
    end else begin
      sel_s = '0;
    end
  end

  assign read_done_s = bus_ready_s & ~bus.we;

  // Read-select alignment and error log; an error sets the flag even while clearing.
  always_comb begin
    rd_sel_d   = rd_sel_q;
    rd_valid_d = read_done_s;
    sticky_d   = sticky_q;
    err_addr_d = err_addr_q;
    if (read_done_s) begin
      rd_sel_d = err_s ? RS_W'(NUM_SLV) : cur_idx_s;
    end else begin
      rd_sel_d = rd_sel_q;
    end
    if (err_s) begin
      sticky_d = 1'b1;
      if (!sticky_q) begin
        err_addr_d = bus.addr;
      end else begin
        err_addr_d = err_addr_q;
      end
    end else if (bus.err_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  assign bus.slv_sel      = sel_s;
  assign bus.slv_we       = sel_s & {NUM_SLV{bus.we}};
  assign bus.bus_ready    = bus_ready_s;
  assign bus.err_pulse    = err_s;
  assign bus.rd_sel       = rd_sel_q;
  assign bus.rd_sel_valid = rd_valid_q;
  assign bus.err_sticky   = sticky_q;
  assign bus.err_addr     = err_addr_q;

endmodule

// File: tb/tb_soc_addr_decoder_n.sv
// Directed plus randomized bench for soc_addr_decoder_n with a transaction-level reference model.
module tb_soc_addr_decoder_n;
  localparam int NS = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  soc_addr_decoder_n_if #(.ADDR_W(32), .NUM_SLV(NS)) bus ();

  soc_addr_decoder_n #(
    .ADDR_W(32), .NUM_SLV(NS), .SEL_HI(11), .SEL_LO(8),
    .PERIPH_BASE(8), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Expected registered state for the cycle being observed.
  int          m_rd_sel   = NS;
  bit          m_rdv      = 1'b0;
  bit          m_sticky   = 1'b0;
  logic [31:0] m_err_addr = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_regs();
    chk("rd_sel",       {29'd0, bus.rd_sel},     32'(m_rd_sel));
    chk("rd_sel_valid", {31'd0, bus.rd_sel_valid}, {31'd0, m_rdv});
    chk("err_sticky",   {31'd0, bus.err_sticky},   {31'd0, m_sticky});
    chk("err_addr",     bus.err_addr,              m_err_addr);
  endtask

  // Region map: code 0 -> memory, codes 8..8+NS-2 -> peripherals 1..NS-1, else unmapped (-1).
  function automatic int decode(input logic [31:0] a);
    int code;
    code = int'((a >> 8) & 32'hF);
    if (code == 0) return 0;
    if (code >= 8 && code <= 8 + NS - 2) return code - 7;
    return -1;
  endfunction

  // One access: target not ready for d cycles; stop_after>0 abandons it early.
  task automatic access(input logic [31:0] a, input logic w, input int d,
                        input logic clr, input int stop_after);
    int idx, last;
    bit err;
    logic [3:0] rdy, exp_sel;
    idx  = decode(a);
    err  = (idx < 0) || (d > TO);
    last = (idx < 0) ? 1 : ((d <= TO) ? d + 1 : TO + 1);
    for (int c = 1; c <= last; c++) begin
      if (stop_after > 0 && c > stop_after) break;
      @(negedge clk);
      rdy = 4'($urandom);
      if (idx >= 0) rdy[idx[1:0]] = (c > d);
      bus.req = 1'b1; bus.we = w; bus.addr = a; bus.slv_ready = rdy;
      bus.err_clr = clr && (c == last);
      #2;
      chk_regs();
      exp_sel = 4'd0;
      if (idx >= 0 && !(err && c == last)) exp_sel[idx[1:0]] = 1'b1;
      chk("slv_sel",   {28'd0, bus.slv_sel},   {28'd0, exp_sel});
      chk("slv_we",    {28'd0, bus.slv_we},    {28'd0, (w ? exp_sel : 4'd0)});
      chk("bus_ready", {31'd0, bus.bus_ready}, {31'd0, (c == last)});
      chk("err_pulse", {31'd0, bus.err_pulse}, {31'd0, (err && c == last)});
      if (c == last) begin
        if (err) begin
          if (!m_sticky) m_err_addr = a;
          m_sticky = 1'b1;
        end else if (clr) begin
          m_sticky = 1'b0;
        end
        m_rdv = !w;
        if (!w) m_rd_sel = err ? NS : idx;
      end else begin
        m_rdv = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic clr);
    @(negedge clk);
    bus.req = 1'b0; bus.we = 1'($urandom); bus.addr = $urandom;
    bus.slv_ready = 4'($urandom); bus.err_clr = clr;
    #2;
    chk_regs();
    chk("idle_sel",   {28'd0, bus.slv_sel},   32'd0);
    chk("idle_ready", {31'd0, bus.bus_ready}, 32'd0);
    chk("idle_err",   {31'd0, bus.err_pulse}, 32'd0);
    if (clr) m_sticky = 1'b0;
    m_rdv = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sel",    {28'd0, bus.slv_sel},      32'd0);
    chk("rst_we",     {28'd0, bus.slv_we},       32'd0);
    chk("rst_ready",  {31'd0, bus.bus_ready},    32'd0);
    chk("rst_errp",   {31'd0, bus.err_pulse},    32'd0);
    chk("rst_rdsel",  {29'd0, bus.rd_sel},       32'(NS));
    chk("rst_rdv",    {31'd0, bus.rd_sel_valid}, 32'd0);
    chk("rst_sticky", {31'd0, bus.err_sticky},   32'd0);
    chk("rst_eaddr",  bus.err_addr,              32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          code, d;
    logic        w, clr;

    // Reset with a live request: selects must stay low.
    rst_n = 1'b0;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h4; bus.slv_ready = 4'b0001; bus.err_clr = 1'b0;
    #7;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);

    access(32'h0000_0004, 1'b1, 0, 1'b0, 0);
    access(32'h0000_0900, 1'b0, 3, 1'b0, 0);
    access(32'h0000_0B00, 1'b0, 0, 1'b0, 0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Timeout, then a second error must not overwrite the logged address.
    access(32'h0000_0800, 1'b1, 100, 1'b0, 0);
    access(32'h0000_0300, 1'b0, 0, 1'b0, 0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    access(32'h0000_0F00, 1'b1, 0, 1'b1, 0);
    idle(1'b0);

    // Ready exactly on the timeout cycle completes cleanly.
    access(32'h0000_0900, 1'b0, TO, 1'b0, 0);

    access(32'h0000_0800, 1'b0, 0, 1'b0, 0);
    access(32'h0000_0A00, 1'b0, 0, 1'b0, 0);
    idle(1'b0);

    // Reset in the middle of a wait aborts the access.
    access(32'h0000_0900, 1'b0, 50, 1'b0, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_rd_sel = NS; m_rdv = 1'b0; m_sticky = 1'b0; m_err_addr = 32'd0;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 1'b0;
    idle(1'b0);
    idle(1'b0);

    for (int i = 0; i < 60; i++) begin
      code = $urandom_range(0, 15);
      a    = ($urandom & 32'hFFFF_F0FF) | (32'(code) << 8);
      w    = 1'($urandom);
      d    = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 18) : $urandom_range(0, 3);
      clr  = ($urandom_range(0, 5) == 0);
      access(a, w, d, clr, 0);
      if ($urandom_range(0, 3) == 0) idle(1'($urandom));
    end
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/soc_addr_decoder_n.md
Name: soc_addr_decoder_n

Overview:
- Parametrised SoC address decoder and bus arbiter between the MIPS data port and N slaves: slave 0 is data memory, slaves 1..N-1 are memory-mapped accelerators/GPIO.
- Adds over the fixed 3-slave decoder: a generic region map, per-slave wait-state handshake, a registered read-select aligned to synchronous read data, a timeout, and sticky bus-error capture.

Parameters:
- ADDR_W, 32, address width.
- NUM_SLV, 4, number of slaves; must be at least 2.
- SEL_HI, 11, MSB of the region field in addr.
- SEL_LO, 8, LSB of the region field.
- PERIPH_BASE, 8, region code of slave 1; slave k (k≥1) uses code PERIPH_BASE+k-1.
- TIMEOUT, 15, maximum wait cycles before bus error; 1..255.
- RS_W, clog2(NUM_SLV+1), rd_sel width.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- req, in, 1, master access valid; master holds req/we/addr stable until bus_ready.
- we, in, 1, write when 1, read when 0.
- addr, in, ADDR_W, byte address.
- slv_ready, in, NUM_SLV, per-slave ready.
- err_clr, in, 1, clears the sticky error.
- slv_sel, out, NUM_SLV, one-hot slave select.
- slv_we, out, NUM_SLV, one-hot write enable, equal to slv_sel & we.
- bus_ready, out, 1, access completes this cycle.
- rd_sel, out, RS_W, registered read-mux select; value NUM_SLV means drive zero.
- rd_sel_valid, out, 1, one-cycle pulse the cycle after a read completes.
- err_pulse, out, 1, one-cycle pulse on an unmapped or timed-out access.
- err_sticky, out, 1, latched error flag.
- err_addr, out, ADDR_W, address of the first error since the last clear.

Behaviour:
- Decode (combinational from addr):
  - code = addr[SEL_HI:SEL_LO].
  - code 0 selects slave 0.
  - code PERIPH_BASE..PERIPH_BASE+NUM_SLV-2 selects slave code-PERIPH_BASE+1.
  - Any other code is unmapped.
- Reset: state IDLE, wait counter 0, rd_sel=NUM_SLV, rd_sel_valid=0, err_pulse=0, err_sticky=0, err_addr=0. slv_sel, slv_we and bus_ready are all 0 while rst_n is low.
- IDLE, req=0: all selects 0, bus_ready=0.
- IDLE, req=1, mapped slave idx:
  - slv_sel[idx]=1 and slv_we[idx]=we in the same cycle.
  - If slv_ready[idx]=1: bus_ready=1 and the state stays IDLE.
  - Otherwise: capture idx, clear the counter, go to WAIT.
- IDLE, req=1, unmapped:
  - No select is asserted.
  - bus_ready=1 and err_pulse=1 in the same cycle.
  - The error is logged.
  - A read returns zero: rd_sel=NUM_SLV and rd_sel_valid=1 on the next cycle.
- WAIT:
  - slv_sel/slv_we for the captured idx are held every cycle; the slave commits a write only on its ready cycle.
  - Counter increments each cycle.
  - slv_ready[idx]=1: bus_ready=1, go to IDLE.
  - Counter reaches TIMEOUT with no ready: bus_ready=1, err_pulse=1, error logged, selects deasserted that cycle, go to IDLE. A read returns zero (rd_sel=NUM_SLV).
  - Ready and timeout in the same cycle: ready wins, no error.
- Read data path:
  - On any read completion (bus_ready=1 and we=0), rd_sel is registered with the source index and rd_sel_valid pulses next cycle.
  - Writes leave rd_sel unchanged and do not pulse rd_sel_valid.
- Latency:
  - Ready slave: 1-cycle access, with read data selected at cycle+1.
  - Waited access: completes 1+w cycles after req, where w ≤ TIMEOUT.
- Error log:
  - err_addr is loaded only when err_sticky=0.
  - An error in the same cycle as err_clr sets the flag and loads err_addr; set wins over clear.
  - err_clr alone clears err_sticky; err_addr is retained.
- Back-to-back: a new req in the cycle after bus_ready is decoded normally; there is no dead cycle.
- Reset during WAIT aborts the access; there is no bus_ready or error afterwards.
- slv_ready of unselected slaves is ignored.

Test Plan:
- Defaults; req=1, we=1, addr=0x0000_0004, slv_ready=4'b0001 -> slv_we=4'b0001, bus_ready=1 in the same cycle, no rd_sel_valid.
- Read addr=0x0000_0900, slv_ready[2] low for 3 cycles -> slv_sel=4'b0100 held for 4 cycles, bus_ready on the 4th; next cycle rd_sel=2, rd_sel_valid=1.
- Read addr=0x0000_0B00 (unmapped) -> slv_sel=0, bus_ready=1, err_pulse=1, err_sticky=1, err_addr=0xB00; next cycle rd_sel=4, rd_sel_valid=1.
- Write addr=0x0000_0800, slave 1 never ready -> bus_ready and err_pulse at cycle 16 (TIMEOUT=15), slv_we[1] deasserted that cycle; a second error at 0x300 leaves err_addr=0x800; err_clr then clears err_sticky.
- Error and err_clr in the same cycle -> err_sticky stays 1; rst_n low during WAIT -> all outputs at reset values immediately, and no bus_ready after release.
- Back-to-back reads to 0x800 then 0xA00, both ready -> bus_ready for 2 consecutive cycles; rd_sel is 1 then 3 on the following cycles.
